load_store_unit: RTL

Initiator side of the data-memory port: accepts one load or store request at a time from the core's memory stage and drives the word-organised data memory. Sub-word stores are performed as read-modify-write, since the memory writes whole words only. Loaded bytes and halfwords are extracted and sign- or zero-extended. Misaligned and out-of-range accesses are rejected without touching memory.

---
 rtl/lsu_pkg.sv | 35 +++
 rtl/lsu_if.sv | 32 +++
 rtl/lane_align.sv | 46 ++++
 rtl/load_store_unit.sv | 97 +++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and request-classification helpers for the load/store unit.
package lsu_pkg;

  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } dat_op_e;

  // Store encodings share the signed load codes.
  localparam dat_op_e SB = LB;
  localparam dat_op_e SH = LH;
  localparam dat_op_e SW = LW;

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_e;

  function automatic logic is_illegal_op(input logic [2:0] op, input logic write);
    case (op)
      LB, LH, LW: return 1'b0;
      LBU, LHU:   return write;
      default:    return 1'b1;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [2:0] op, input logic [1:0] addr_lo);
    case (op[1:0])
      2'b01:   return addr_lo[0];
      2'b10:   return addr_lo != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Core request/response channel plus data-memory port of the load/store unit.
interface lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_dat_op;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_w_dat;
  logic [2:0]  mem_dat_op;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_r_dat;

  // master: core plus memory environment; slave: the load/store unit
  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_dat_op, rsp_ready, mem_r_dat,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
           mem_addr, mem_w_dat, mem_dat_op, mem_read, mem_write
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_dat_op, rsp_ready, mem_r_dat,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
           mem_addr, mem_w_dat, mem_dat_op, mem_read, mem_write
  );
endinterface

// File: rtl/lane_align.sv
// Byte/halfword lane handling: load extract with sign/zero extension and
// sub-word store merge into a previously read word. Purely combinational.
module lane_align
  import lsu_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] rdata_ext,
  output logic [31:0] merged
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
    byte_sel  = word[{addr_lo, 3'b000} +: 8];
    half_sel  = addr_lo[1] ? word[31:16] : word[15:0];
    rdata_ext = word;
    merged    = wdata;

    case (op)
      LB:      rdata_ext = {{24{byte_sel[7]}}, byte_sel};
      LBU:     rdata_ext = {24'h000000, byte_sel};
      LH:      rdata_ext = {{16{half_sel[15]}}, half_sel};
      LHU:     rdata_ext = {16'h0000, half_sel};
      default: rdata_ext = word;
    endcase

    case (op[1:0])
      2'b00: begin
        merged = word;
        merged[{addr_lo, 3'b000} +: 8] = wdata[7:0];
      end
      2'b01: begin
        merged = word;
        if (addr_lo[1]) merged[31:16] = wdata[15:0];
        else            merged[15:0]  = wdata[15:0];
      end
      default: merged = wdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: one load/store at a time, sub-word stores done as
// read-modify-write, bad requests answered with an error and no memory access.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_WORDS = 32
) (
  input logic  clk,
  input logic  rst_n,
  lsu_if.slave bus
);

  localparam logic [31:0] ADDR_LIMIT = 32'(4 * MEM_WORDS);

  state_e      state, state_nxt;
  logic [31:0] addr_q;
  logic [31:0] buf_q;    // store data on accept, merged word after RD
  logic [31:0] rdata_q;
  logic [2:0]  op_q;
  logic        write_q;
  logic        err_q;
  logic        req_err;
  logic        accept;
  logic [31:0] rdata_ext;
  logic [31:0] merged;

  assign accept  = (state == IDLE) && bus.req_valid;
  assign req_err = is_illegal_op(bus.req_dat_op, bus.req_write)
                || is_misaligned(bus.req_dat_op, bus.req_addr[1:0])
                || (bus.req_addr >= ADDR_LIMIT);

  lane_align u_lane_align (
    .op        (op_q),
    .addr_lo   (addr_q[1:0]),
    .word      (bus.mem_r_dat),
    .wdata     (buf_q),
    .rdata_ext (rdata_ext),
    .merged    (merged)
  );

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.req_valid) begin
        if (req_err)                                   state_nxt = RESP;
        else if (!bus.req_write || bus.req_dat_op != SW) state_nxt = RD;
        else                                           state_nxt = WR;
      end
      RD:      state_nxt = write_q ? WR : RESP;
      WR:      state_nxt = RESP;
      RESP:    if (bus.rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Strobes come straight from state so reset removes them immediately.
  always_comb begin
    bus.req_ready = (state == IDLE);
    bus.rsp_valid = (state == RESP);
    bus.mem_read  = (state == RD);
    bus.mem_write = (state == WR);
    bus.mem_w_dat = (state == WR) ? buf_q : 32'h0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      buf_q   <= '0;
      rdata_q <= '0;
      op_q    <= '0;
      write_q <= 1'b0;
      err_q   <= 1'b0;
    end else if (accept) begin
      addr_q  <= bus.req_addr;
      buf_q   <= bus.req_wdata;
      rdata_q <= '0;
      op_q    <= bus.req_dat_op;
      write_q <= bus.req_write;
      err_q   <= req_err;
    end else if (state == RD) begin
      if (write_q) buf_q   <= merged;
      else         rdata_q <= rdata_ext;
    end
  end

  assign bus.rsp_rdata  = rdata_q;
  assign bus.rsp_err    = err_q;
  assign bus.mem_addr   = {addr_q[31:2], 2'b00};
  assign bus.mem_dat_op = op_q;

endmodule
